// File: rtl/uart_rx_param.sv
// Parametrised UART receiver (sync + 3-sample vote), word out (H+2) cycles into the last stop bit.
// Holds one word under valid/ready; a frame completing while the word is unaccepted is dropped with an overrun pulse.
module uart_rx_param #(
    parameter int CLK_PER_BIT = 434,
    parameter int DATA_BITS   = 7,
    parameter int PARITY      = 1,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);
    localparam int H  = CLK_PER_BIT / 2;
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] SMP0      = CW'(H - 1);
    localparam logic [CW-1:0] SMP1      = CW'(H);
    localparam logic [CW-1:0] DEC       = CW'(H + 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK} state_t;

    state_t                 state_q, state_d;
    logic                   sync_q, rx_s_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [1:0]             smp_q, smp_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   fperr_q, fperr_d, fferr_q, fferr_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic                   bit_dec, decide, done, ferr_now;

    // Third vote is the live sample at the decision count.
    assign bit_dec = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
    assign decide  = (state_q != S_IDLE) && (state_q != S_BREAK) && (cnt_q == DEC);

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        smp_d    = smp_q;
        shift_d  = shift_q;
        fperr_d  = fperr_q;
        fferr_d  = fferr_q;
        data_d   = data_q;
        valid_d  = valid_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        ovr_d    = 1'b0;
        done     = 1'b0;
        ferr_now = fferr_q | ~bit_dec;

        if (cnt_q == SMP0) smp_d[0] = rx_s_q;
        if (cnt_q == SMP1) smp_d[1] = rx_s_q;

        if (state_q == S_IDLE || state_q == S_BREAK) cnt_d = '0;
        else if (cnt_q == CNT_LAST)                  cnt_d = '0;
        else                                         cnt_d = cnt_q + CW'(1);

        case (state_q)
            S_IDLE: begin
                // The detecting cycle is count 0 of the start bit.
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = CW'(1);
                end
            end
            S_START: begin
                if (decide) begin
                    if (bit_dec) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        bit_d   = '0;
                        fperr_d = 1'b0;
                        fferr_d = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (decide) begin
                    shift_d = {bit_dec, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end
                end
            end
            S_PAR: begin
                if (decide) begin
                    fperr_d = (^shift_q ^ bit_dec) != (PARITY == 2);
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (decide) begin
                    fferr_d = ferr_now;
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == STOP_LAST) begin
                        done    = 1'b1;
                        bit_d   = '0;
                        state_d = ferr_now ? S_BREAK : S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (valid_q && data_ready) begin
            valid_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
        end
        if (done) begin
            if (!valid_q || data_ready) begin
                data_d  = shift_q;
                perr_d  = fperr_q;
                ferr_d  = ferr_now;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            smp_q   <= '0;
            shift_q <= '0;
            fperr_q <= 1'b0;
            fferr_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= rx;
            rx_s_q  <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            smp_q   <= smp_d;
            shift_q <= shift_d;
            fperr_q <= fperr_d;
            fferr_q <= fferr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign overrun_err = ovr_q;
    assign busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: six receiver configurations share one serial line and reset.
module tb_uart_rx_param;
    localparam int NI  = 6;
    localparam int CPB = 16;
    localparam int DB_T [NI] = '{8, 8, 8, 8, 5, 9};
    localparam int PA_T [NI] = '{1, 2, 0, 0, 1, 1};
    localparam int SB_T [NI] = '{1, 1, 1, 2, 1, 1};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic [NI-1:0] vld, rdy, perr, ferr, ovr, bsy;
    logic [8:0]    dout [NI];

    int tests = 0;
    int fails = 0;
    int ovr_cnt = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [DB_T[g]-1:0] d;
        uart_rx_param #(
            .CLK_PER_BIT(CPB), .DATA_BITS(DB_T[g]), .PARITY(PA_T[g]), .STOP_BITS(SB_T[g])
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .rx(rx),
            .data_out(d), .data_valid(vld[g]), .data_ready(rdy[g]),
            .parity_err(perr[g]), .frame_err(ferr[g]), .overrun_err(ovr[g]), .busy(bsy[g])
        );
        assign dout[g] = 9'(d);
    end

    always @(negedge clk) if (ovr[0]) ovr_cnt <= ovr_cnt + 1;

    typedef struct {
        int         cfg;
        logic [8:0] data;
        int         pforce;   // 0 correct parity, 1 force 0, 2 force 1
        bit         stop_bad; // last stop bit sent as 0
        int         spike;    // frame bit index carrying a 1-cycle inverted spike, -1 none
        logic [8:0] exp_d;
        logic       exp_p;
        logic       exp_f;
    } vec_t;

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rx    = 1'b1;
        rdy   = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input int cfg, input logic [8:0] data, input int pforce,
                              input bit stop_bad, input int spike, input bit hold_low);
        logic b [16];
        int   n;
        logic p;
        n = 0;
        p = 1'b0;
        b[n++] = 1'b0;
        for (int i = 0; i < DB_T[cfg]; i++) begin
            b[n++] = data[i];
            p = p ^ data[i];
        end
        if (PA_T[cfg] != 0) begin
            if (PA_T[cfg] == 2) p = ~p;
            if (pforce == 1) p = 1'b0;
            if (pforce == 2) p = 1'b1;
            b[n++] = p;
        end
        for (int i = 0; i < SB_T[cfg]; i++) b[n++] = 1'b1;
        if (stop_bad) b[n-1] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            rx = b[i];
            if (i == spike) begin
                repeat (8) @(negedge clk);
                rx = ~b[i];
                @(negedge clk);
                rx = b[i];
                repeat (7) @(negedge clk);
            end else begin
                repeat (CPB) @(negedge clk);
            end
        end
        if (!hold_low) rx = 1'b1;
    endtask

    task automatic wait_vld(input int c, input string name);
        int k;
        k = 0;
        while (!vld[c] && k < 64) begin
            @(negedge clk);
            k++;
        end
        chk(name, 9'(vld[c]), 9'h1);
    endtask

    vec_t vt [9];
    int   lat;
    int   base;

    initial begin
        #1_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{0, 9'h0A5, 0, 1'b0, -1, 9'h0A5, 1'b0, 1'b0};
        vt[1] = '{1, 9'h03C, 1, 1'b0, -1, 9'h03C, 1'b1, 1'b0};
        vt[2] = '{2, 9'h03C, 0, 1'b0, -1, 9'h03C, 1'b0, 1'b0};
        vt[3] = '{0, 9'h03C, 2, 1'b0, -1, 9'h03C, 1'b1, 1'b0};
        vt[4] = '{4, 9'h015, 0, 1'b0, -1, 9'h015, 1'b0, 1'b0};
        vt[5] = '{5, 9'h1A5, 0, 1'b0, -1, 9'h1A5, 1'b0, 1'b0};
        vt[6] = '{0, 9'h05A, 0, 1'b1, -1, 9'h05A, 1'b0, 1'b1};
        vt[7] = '{3, 9'h081, 0, 1'b0, -1, 9'h081, 1'b0, 1'b0};
        vt[8] = '{0, 9'h0FF, 0, 1'b0, 4,  9'h0FF, 1'b0, 1'b0};

        rdy = '0;
        repeat (2) @(negedge clk);
        chk("reset_valid", 9'(vld[0]), 9'h0);
        chk("reset_data", dout[0], 9'h0);
        chk("reset_busy", 9'(bsy[0]), 9'h0);
        chk("reset_flags", {6'b0, perr[0], ferr[0], ovr[0]}, 9'h0);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            send_frame(vt[i].cfg, vt[i].data, vt[i].pforce, vt[i].stop_bad, vt[i].spike, 1'b0);
            wait_vld(vt[i].cfg, $sformatf("vec%0d_valid", i));
            chk($sformatf("vec%0d_data", i), dout[vt[i].cfg], vt[i].exp_d);
            chk($sformatf("vec%0d_perr", i), 9'(perr[vt[i].cfg]), 9'(vt[i].exp_p));
            chk($sformatf("vec%0d_ferr", i), 9'(ferr[vt[i].cfg]), 9'(vt[i].exp_f));
            rdy[vt[i].cfg] = 1'b1;
            @(negedge clk);
            rdy[vt[i].cfg] = 1'b0;
            chk($sformatf("vec%0d_accept", i),
                {6'b0, vld[vt[i].cfg], perr[vt[i].cfg], ferr[vt[i].cfg]}, 9'h0);
        end

        // Latency from line drop to data_valid, config 0: 11 bits -> 10*16+10 after rx_s falls.
        do_reset();
        lat = 0;
        fork
            send_frame(0, 9'h0A5, 0, 1'b0, -1, 1'b0);
            begin
                @(negedge clk);
                while (!vld[0] && lat < 400) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
            end
        join
        chk("latency", 9'(lat), 9'd172);

        // Start glitch: 4 low cycles.
        do_reset();
        base = ovr_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        chk("glitch_busy_hi", 9'(bsy[0]), 9'h1);
        repeat (20) @(negedge clk);
        chk("glitch_busy_lo", 9'(bsy[0]), 9'h0);
        chk("glitch_noflags", {5'b0, vld[0], perr[0], ferr[0], 1'b0}, 9'h0);
        chk("glitch_noovr", 9'(ovr_cnt - base), 9'h0);

        // Second stop bit low then line held low: break.
        do_reset();
        send_frame(3, 9'h0C3, 0, 1'b1, -1, 1'b1);
        repeat (48) @(negedge clk);
        chk("break_valid", 9'(vld[3]), 9'h1);
        chk("break_data", dout[3], 9'h0C3);
        chk("break_ferr", 9'(ferr[3]), 9'h1);
        chk("break_busy", 9'(bsy[3]), 9'h1);
        rdy[3] = 1'b1;
        @(negedge clk);
        rdy[3] = 1'b0;
        repeat (32) @(negedge clk);
        chk("break_noframe", 9'(vld[3]), 9'h0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("break_idle", 9'(bsy[3]), 9'h0);

        // Overrun: two frames back-to-back, nothing accepted.
        do_reset();
        base = ovr_cnt;
        send_frame(0, 9'h011, 0, 1'b0, -1, 1'b0);
        chk("ovr_first_valid", 9'(vld[0]), 9'h1);
        chk("ovr_none_yet", 9'(ovr_cnt - base), 9'h0);
        send_frame(0, 9'h022, 0, 1'b0, -1, 1'b0);
        repeat (4) @(negedge clk);
        chk("ovr_pulse_count", 9'(ovr_cnt - base), 9'h1);
        chk("ovr_data_kept", dout[0], 9'h011);
        chk("ovr_valid_kept", 9'(vld[0]), 9'h1);

        // Reset mid-DATA while an old word is held, then a clean frame.
        do_reset();
        send_frame(0, 9'h0A5, 0, 1'b0, -1, 1'b0);
        fork
            send_frame(0, 9'h05A, 0, 1'b0, -1, 1'b0);
            begin
                repeat (CPB * 4) @(negedge clk);
                chk("rst_busy_before", 9'(bsy[0]), 9'h1);
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                chk("rst_outputs", {bsy[0], vld[0], perr[0], ferr[0], ovr[0], 4'b0}, 9'h0);
                chk("rst_data", dout[0], 9'h0);
            end
        join
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(0, 9'h05A, 0, 1'b0, -1, 1'b0);
        wait_vld(0, "rst_after_valid");
        chk("rst_after_data", dout[0], 9'h05A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
